// File: rtl/rx_iq_mux_serializer_pkg.sv
// Shared types and helpers for the protocol-2 Rx I/Q serializer.
// Latency: n/a (types, constant functions and a pure byte-select function).
// Backpressure: n/a.
package rx_p2_pkg;

  typedef enum logic [1:0] {
    ST_CLEAR = 2'd0,
    ST_IDLE  = 2'd1,
    ST_SEND  = 2'd2
  } state_t;

  // Byte n of a word, where n=0 is the least significant byte.
  function automatic logic [7:0] byte_sel(input logic [31:0] word, input logic [1:0] n);
    return word[{n, 3'b000} +: 8];
  endfunction

  // Only whole-byte sample widths that the Ethernet framing supports.
  function automatic bit sample_w_ok(input int w);
    return (w == 16) || (w == 24) || (w == 32);
  endfunction

endpackage

// File: rtl/rx_iq_mux_serializer_if.sv
// Byte stream from the serializer into the Rx Ethernet FIFO.
// Latency: n/a (wires only).
// Backpressure: fifo_afull from the FIFO stalls wrenable.
//   master: serializer (drives wrenable/data_out/fifo_clear)
//   slave : FIFO (drives fifo_afull)
interface rx_iq_mux_serializer_if;
  logic       wrenable;
  logic [7:0] data_out;
  logic       fifo_clear;
  logic       fifo_afull;

  modport master (output wrenable, output data_out, output fifo_clear, input fifo_afull);
  modport slave  (input wrenable, input data_out, input fifo_clear, output fifo_afull);
endinterface

// File: rtl/rx_iq_mux_serializer_mask_scan.sv
// Finds the next receiver to send: lowest set mask bit above cur (or from 0 when start=1).
// Latency: combinational.
// Backpressure: none.
//   mask/cur/start in; nxt = next index, last = no further set bit.
module rx_mask_scan #(
  parameter int NR  = 8,
  parameter int RXW = 3
) (
  input  logic [NR-1:0]  mask,
  input  logic [RXW-1:0] cur,
  input  logic           start,
  output logic [RXW-1:0] nxt,
  output logic           last
);

  // Descending walk so the lowest qualifying index wins.
  always_comb begin
    nxt  = '0;
    last = 1'b1;
    for (int i = NR - 1; i >= 0; i--) begin
      if (mask[i] && (start || (RXW'(i) > cur))) begin
        nxt  = RXW'(i);
        last = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rx_iq_mux_serializer.sv
// Serialises I/Q of the base receiver plus every sync_mask receiver into bytes for the Rx FIFO.
// Latency: first byte the cycle after the base spd_rdy rising edge; one byte per cycle after that.
// Backpressure: fifo_afull holds wrenable low and freezes the byte position in the same cycle.
//   clock/reset_n, sample_rate/sync_mask/base_rx (config), data_in_I/Q + spd_rdy (DDC side),
//   fifo (byte stream master), drop_count (saturating dropped-frame count).
module rx_iq_mux_serializer
  import rx_p2_pkg::*;
#(
  parameter int NR        = 8,
  parameter int SAMPLE_W  = 24,
  parameter int CLEAR_CYC = 4,
  localparam int BPS      = 2 * SAMPLE_W / 8,
  localparam int RXW      = (NR > 1) ? $clog2(NR) : 1
) (
  input  logic                   clock,
  input  logic                   reset_n,
  input  logic [15:0]            sample_rate,
  input  logic [NR-1:0]          sync_mask,
  input  logic [RXW-1:0]         base_rx,
  input  logic [NR*SAMPLE_W-1:0] data_in_I,
  input  logic [NR*SAMPLE_W-1:0] data_in_Q,
  input  logic [NR-1:0]          spd_rdy,
  rx_iq_mux_serializer_if.master fifo,
  output logic [7:0]             drop_count
);

  if (!sample_w_ok(SAMPLE_W) || NR < 1 || NR > 8 || CLEAR_CYC < 1) begin : g_bad_param
    $error("rx_iq_mux_serializer: illegal NR/SAMPLE_W/CLEAR_CYC");
  end

  localparam int BCW = $clog2(BPS);
  localparam int CCW = (CLEAR_CYC > 1) ? $clog2(CLEAR_CYC) : 1;
  localparam logic [BCW-1:0] HB_L     = BCW'(SAMPLE_W / 8);
  localparam logic [BCW-1:0] HB_M1    = BCW'(SAMPLE_W / 8 - 1);
  localparam logic [BCW-1:0] BPS_M1   = BCW'(BPS - 1);
  localparam logic [CCW-1:0] CLR_LAST = CCW'(CLEAR_CYC - 1);
  localparam logic [RXW:0]   NR_L     = (RXW + 1)'(NR);

  state_t              state, state_nxt;
  logic [SAMPLE_W-1:0] cap_i [NR];
  logic [SAMPLE_W-1:0] cap_q [NR];
  logic [SAMPLE_W-1:0] frm_i [NR];
  logic [SAMPLE_W-1:0] frm_q [NR];
  logic [NR-1:0]       spd_q;
  logic [15:0]         prev_rate;
  logic [NR-1:0]       prev_mask;
  logic [RXW-1:0]      prev_base;
  logic [NR-1:0]       rest_mask;   // receivers still to follow the base one
  logic [RXW-1:0]      cur_rx;
  logic                on_base;     // currently sending the base receiver
  logic [BCW-1:0]      byte_idx;
  logic [CCW-1:0]      clr_cnt;
  logic [RXW-1:0]      base_eff;
  logic [NR-1:0]       base_oh;
  logic [RXW-1:0]      scan_nxt;
  logic                scan_last;
  logic                trigger, cfg_chg, byte_go, rx_done;
  logic [SAMPLE_W-1:0] word;
  logic [BCW-1:0]      nsel;

  assign base_eff = ({1'b0, base_rx} >= NR_L) ? '0 : base_rx;
  assign base_oh  = NR'(1) << base_eff;
  assign trigger  = spd_rdy[base_eff] & ~spd_q[base_eff];
  assign cfg_chg  = (sample_rate != prev_rate) || (sync_mask != prev_mask) || (base_rx != prev_base);
  assign byte_go  = (state == ST_SEND) && !fifo.fifo_afull;
  assign rx_done  = byte_go && (byte_idx == BPS_M1);

  rx_mask_scan #(.NR(NR), .RXW(RXW)) u_scan (
    .mask  (rest_mask),
    .cur   (cur_rx),
    .start (on_base),
    .nxt   (scan_nxt),
    .last  (scan_last)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= ST_CLEAR;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_CLEAR: if (clr_cnt == CLR_LAST) state_nxt = ST_IDLE;
      ST_IDLE: begin
        if (cfg_chg)      state_nxt = ST_CLEAR;
        else if (trigger) state_nxt = ST_SEND;
      end
      ST_SEND: begin
        if (cfg_chg)                    state_nxt = ST_CLEAR;
        else if (rx_done && scan_last)  state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_CLEAR;
    endcase
  end

  // Bytes go I MSB..LSB then Q MSB..LSB of the current receiver.
  always_comb begin
    word = '0;
    nsel = '0;
    if (byte_idx < HB_L) begin
      word = frm_i[cur_rx];
      nsel = HB_M1 - byte_idx;
    end else begin
      word = frm_q[cur_rx];
      nsel = BPS_M1 - byte_idx;
    end
    fifo.wrenable   = byte_go;
    fifo.fifo_clear = (state == ST_CLEAR);
    fifo.data_out   = (state == ST_SEND) ? byte_sel(32'(word), nsel[1:0]) : 8'h00;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      spd_q      <= '0;
      prev_rate  <= '0;
      prev_mask  <= '0;
      prev_base  <= '0;
      rest_mask  <= '0;
      cur_rx     <= '0;
      on_base    <= 1'b0;
      byte_idx   <= '0;
      clr_cnt    <= '0;
      drop_count <= '0;
      for (int i = 0; i < NR; i++) begin
        cap_i[i] <= '0;
        cap_q[i] <= '0;
        frm_i[i] <= '0;
        frm_q[i] <= '0;
      end
    end else begin
      spd_q <= spd_rdy;
      for (int i = 0; i < NR; i++) begin
        if (spd_rdy[i]) begin
          cap_i[i] <= data_in_I[i*SAMPLE_W +: SAMPLE_W];
          cap_q[i] <= data_in_Q[i*SAMPLE_W +: SAMPLE_W];
        end
      end

      clr_cnt <= (state == ST_CLEAR) ? clr_cnt + 1'b1 : '0;
      if (state == ST_CLEAR) begin
        prev_rate <= sample_rate;
        prev_mask <= sync_mask;
        prev_base <= base_rx;
      end

      // Any trigger that cannot start a frame is a drop, including one racing a config change.
      if (trigger && ((state != ST_IDLE) || cfg_chg) && (drop_count != 8'hFF))
        drop_count <= drop_count + 8'd1;

      if ((state == ST_IDLE) && trigger && !cfg_chg) begin
        // Receivers strobing right now have fresher data than their capture regs.
        for (int i = 0; i < NR; i++) begin
          frm_i[i] <= spd_rdy[i] ? data_in_I[i*SAMPLE_W +: SAMPLE_W] : cap_i[i];
          frm_q[i] <= spd_rdy[i] ? data_in_Q[i*SAMPLE_W +: SAMPLE_W] : cap_q[i];
        end
        rest_mask <= sync_mask & ~base_oh;
        cur_rx    <= base_eff;
        on_base   <= 1'b1;
        byte_idx  <= '0;
      end else if (byte_go) begin
        if (rx_done) begin
          byte_idx <= '0;
          cur_rx   <= scan_nxt;
          on_base  <= 1'b0;
        end else begin
          byte_idx <= byte_idx + 1'b1;
        end
      end
    end
  end

endmodule
